// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone B4 pipelined initiator with a bus timeout.
// One command at a time in; one response pulse out per finished (or aborted) bus cycle.
module wb_master_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [29:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  input  logic [3:0]  i_cmd_sel,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_timeout,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timeout_q, timeout_d;
  logic        cmd_ready_q, cmd_ready_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_data;
          sel_d   = i_cmd_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          timer_d = 16'd0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        timer_d = timer_q + 16'd1;
        // A slave completion on the expiry cycle still counts as a normal completion.
        if (i_wb_ack || i_wb_err) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = i_wb_err;
          rsp_data_d  = (i_wb_err || we_q) ? 32'd0 : i_wb_data;
          state_d     = S_IDLE;
        end else if (timer_q == TMO_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'd0;
          timeout_d   = 1'b1;
          state_d     = S_IDLE;
        end else if ((state_q == S_REQ) && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Ready is registered so it reads 0 throughout reset and 1 in the response cycle.
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= 16'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 30'd0;
      wdata_q     <= 32'd0;
      sel_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_timeout   = timeout_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;
  assign o_wb_sel    = sel_q;

endmodule
